// File: rtl/la_pkg.sv
// rtl/la_pkg.sv - shared logic-analyzer types: state encoding, default sizes, sample word
// Contents: LA_CH / LA_DEPTH defaults, sample_t (LA_CH-bit probe word), cap_state_t.
package la_pkg;

    localparam int LA_CH    = 4;
    localparam int LA_DEPTH = 1024;

    typedef logic [LA_CH-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - readout stream from capture_ctrl to the host-link stage
// Ports (signals): rd_valid, rd_data[CH], rd_last (master drives); rd_ready (slave drives).
interface capture_ctrl_if
    import la_pkg::*;
#(
    parameter int CH = LA_CH
);
    logic          rd_valid;
    logic [CH-1:0] rd_data;
    logic          rd_last;
    logic          rd_ready;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/capture_ctrl_sample_ram.sv
// rtl/capture_ctrl_sample_ram.sv - simple dual-port sample RAM, 1-cycle synchronous read
// Ports: clk; write port we/waddr/din; read port re/raddr/q (q holds while re=0).
module sample_ram #(
    parameter int W  = 4,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  din,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  q
);
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] q_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= din;
        end
        if (re) begin
            q_q <= mem[raddr];
        end
    end

    assign q = q_q;
endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - capture decimated probe samples into RAM, then stream them out
// Ports: clk, reset (sync, active-high); we, data_in[CH]; div[DIV_W] (CAPTURE_CTRL_DECIM_EN
// only); write_finish, busy; rd (capture_ctrl_if.master: rd_valid/rd_data/rd_last/rd_ready).
// Macro CAPTURE_CTRL_DECIM_EN: adds the div port and sample-rate divider; without it every
// CAPTURE cycle with we=1 stores a sample.
module capture_ctrl
    import la_pkg::*;
#(
    parameter int CH    = LA_CH,
    parameter int DEPTH = LA_DEPTH,
    parameter int AW    = 10
`ifdef CAPTURE_CTRL_DECIM_EN
    ,
    parameter int DIV_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [CH-1:0]    data_in,
`ifdef CAPTURE_CTRL_DECIM_EN
    input  logic [DIV_W-1:0] div,
`endif
    output logic             write_finish,
    output logic             busy,
    capture_ctrl_if.master   rd
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    cap_state_t    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    // One extra bit: rd_addr_q[AW] set means every word has been issued.
    logic [AW:0]   rd_addr_q, rd_addr_d;
    logic          write_finish_q, write_finish_d;
    logic          busy_q, busy_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;
`ifdef CAPTURE_CTRL_DECIM_EN
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
`endif

    logic          tick;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          ram_re;
    logic [CH-1:0] ram_q;

    always_comb begin
        state_d        = state_q;
        wr_addr_d      = wr_addr_q;
        rd_addr_d      = rd_addr_q;
        write_finish_d = write_finish_q;
        rd_valid_d     = rd_valid_q;
        rd_last_d      = rd_last_q;
        ram_we         = 1'b0;
        ram_waddr      = wr_addr_q;
        ram_re         = 1'b0;
`ifdef CAPTURE_CTRL_DECIM_EN
        div_cnt_d      = div_cnt_q;
        // div is compared live; a smaller new div lets the counter run to natural overflow.
        tick           = (div_cnt_q == div);
`else
        tick           = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                // The edge sample is stored in the same cycle we is seen.
                if (we) begin
                    ram_we    = 1'b1;
                    ram_waddr = '0;
                    wr_addr_d = AW'(1);
`ifdef CAPTURE_CTRL_DECIM_EN
                    div_cnt_d = '0;
`endif
                    state_d   = CAPTURE;
                end
            end
            CAPTURE: begin
`ifdef CAPTURE_CTRL_DECIM_EN
                // Counter runs even while we=0 (paused).
                div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
`endif
                if (tick && we) begin
                    ram_we    = 1'b1;
                    wr_addr_d = wr_addr_q + AW'(1);
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d        = READ;
                        write_finish_d = 1'b1;
                    end
                end
            end
            READ: begin
                // Issue a read when the output slot is empty or being emptied this cycle.
                if ((!rd_valid_q || rd.rd_ready) && !rd_addr_q[AW]) begin
                    ram_re     = 1'b1;
                    rd_addr_d  = rd_addr_q + (AW+1)'(1);
                    rd_valid_d = 1'b1;
                    rd_last_d  = (rd_addr_q[AW-1:0] == LAST_ADDR);
                end else if (rd_valid_q && rd.rd_ready) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (rd_last_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CAPTURE) || (state_d == READ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            write_finish_q <= 1'b0;
            busy_q         <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_last_q      <= 1'b0;
`ifdef CAPTURE_CTRL_DECIM_EN
            div_cnt_q      <= '0;
`endif
        end else begin
            state_q        <= state_d;
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            write_finish_q <= write_finish_d;
            busy_q         <= busy_d;
            rd_valid_q     <= rd_valid_d;
            rd_last_q      <= rd_last_d;
`ifdef CAPTURE_CTRL_DECIM_EN
            div_cnt_q      <= div_cnt_d;
`endif
        end
    end

    sample_ram #(
        .W  (CH),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .din   (data_in),
        .re    (ram_re),
        .raddr (rd_addr_q[AW-1:0]),
        .q     (ram_q)
    );

    assign write_finish = write_finish_q;
    assign busy         = busy_q;
    assign rd.rd_valid  = rd_valid_q;
    assign rd.rd_last   = rd_last_q;
    // RAM output register is not reset; gating keeps rd_data at 0 whenever no word is offered.
    assign rd.rd_data   = rd_valid_q ? ram_q : '0;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb/tb_capture_ctrl.sv - scoreboard bench for capture_ctrl (DEPTH=16), honours CAPTURE_CTRL_DECIM_EN
module tb_capture_ctrl;
    import la_pkg::*;

    localparam int CH    = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
`ifdef CAPTURE_CTRL_DECIM_EN
    localparam int DIV_W = 16;
    logic [DIV_W-1:0] div = '0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          we = 1'b0;
    logic [CH-1:0] data_in = '0;
    logic          write_finish;
    logic          busy;

    capture_ctrl_if #(.CH(CH)) rd_if ();

    capture_ctrl #(
        .CH    (CH),
        .DEPTH (DEPTH),
`ifdef CAPTURE_CTRL_DECIM_EN
        .AW    (AW),
        .DIV_W (DIV_W)
`else
        .AW    (AW)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .data_in      (data_in),
`ifdef CAPTURE_CTRL_DECIM_EN
        .div          (div),
`endif
        .write_finish (write_finish),
        .busy         (busy),
        .rd           (rd_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH-1:0] d;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pops = 0;
    int   mode = 0;   // 0: ready high, 1: pattern 1,0,0,1, 2: ready low

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // rd_ready driver
    initial begin
        int pc;
        logic [3:0] pat;
        pc  = 0;
        pat = 4'b1001;
        rd_if.rd_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: rd_if.rd_ready = 1'b1;
                1: begin
                    rd_if.rd_ready = pat[3 - (pc % 4)];
                    pc++;
                end
                default: rd_if.rd_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on every handshake, checks stability across stalls.
    initial begin
        logic          prev_stall;
        logic [CH-1:0] prev_d;
        logic          prev_l;
        exp_t          e;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_if.rd_valid) begin
                if (prev_stall) begin
                    chk("stall_data", 32'(rd_if.rd_data), 32'(prev_d));
                    chk("stall_last", 32'(rd_if.rd_last), 32'(prev_l));
                end
                if (rd_if.rd_ready) begin
                    if (q.size() == 0) begin
                        chk("unexpected_word", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rd_data", 32'(rd_if.rd_data), 32'(e.d));
                        chk("rd_last", 32'(rd_if.rd_last), 32'(e.l));
                    end
                    pops++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = rd_if.rd_data;
                    prev_l     = rd_if.rd_last;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_write_finish"}, 32'(write_finish), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_if.rd_valid), 32'd0);
        chk({tag, "_rd_last"}, 32'(rd_if.rd_last), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_if.rd_data), 32'd0);
        chk({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        we    = 1'b0;
        step();
        chk_idle(tag);
        reset = 1'b0;
        q.delete();
    endtask

    // Drives we/data_in from the cycle we first rises; data_in = base + cycle.
    // Expected stored words are pushed as the bench decides each write happens.
    task automatic capture(input int dv, input int pause_at, input int pause_len,
                           input int base, input int exp_wf);
        int            got;
        int            writes;
        int            cnt;
        logic          we_c;
        logic [CH-1:0] v;
        got    = -1;
        writes = 0;
        cnt    = 0;
`ifdef CAPTURE_CTRL_DECIM_EN
        div = DIV_W'(dv);
`endif
        for (int c = 0; c < 300; c++) begin
            we_c    = !(c >= pause_at && c < pause_at + pause_len);
            v       = CH'(base + c);
            we      = we_c;
            data_in = v;
            if (writes < DEPTH) begin
                if (c == 0) begin
                    q.push_back('{d: v, l: (writes == DEPTH - 1)});
                    writes++;
                    cnt = 0;
                end else begin
                    if (cnt == dv && we_c) begin
                        q.push_back('{d: v, l: (writes == DEPTH - 1)});
                        writes++;
                    end
                    cnt = (cnt == dv) ? 0 : cnt + 1;
                end
            end
            step();
            if (write_finish) begin
                got = c + 1;
                break;
            end
        end
        we = 1'b0;
        chk("wf_latency", got, exp_wf);
    endtask

    task automatic wait_done(input string tag);
        int n;
        for (n = 0; n < 300; n++) begin
            if (!busy && q.size() == 0) break;
            step();
        end
        chk({tag, "_drain_in_time"}, 32'(n < 300), 32'd1);
        repeat (3) step();
        chk({tag, "_state_done"}, 32'(dut.state_q), 32'(DONE));
        chk({tag, "_write_finish"}, 32'(write_finish), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_if.rd_valid), 32'd0);
        chk({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
    endtask

    initial begin
        int base_pops;
        int n;

        repeat (3) step();
        chk_idle("reset");
        reset = 1'b0;

        // Scenario 1: we at cycle 10, counting data, div=0, ready high.
        mode = 0;
        repeat (9) step();
        capture(0, 999, 0, 0, 16);
        wait_done("s1");
        apply_reset("s1_rst");

`ifdef CAPTURE_CTRL_DECIM_EN
        // Scenario 2: div=2 keeps the edge word then every third value.
        step();
        capture(2, 999, 0, 5, 46);
        wait_done("s2");
        apply_reset("s2_rst");
`endif

        // Scenario 3: we dropped for 5 cycles mid-capture.
        step();
        capture(0, 6, 5, 0, 21);
        wait_done("s3");
        apply_reset("s3_rst");

        // Scenario 4: back-pressure with ready pattern 1,0,0,1.
        mode = 1;
        step();
        capture(0, 999, 0, 3, 16);
        wait_done("s4");
        mode = 0;
        apply_reset("s4_rst");

        // Scenario 5: reset after 7 writes, then a fresh capture.
        step();
        for (int c = 0; c < 7; c++) begin
            we      = 1'b1;
            data_in = CH'(c + 7);
            step();
        end
        reset = 1'b1;
        step();
        chk_idle("midcap_rst");
        reset = 1'b0;
        we    = 1'b0;
        step();
        capture(0, 999, 0, 9, 16);
        wait_done("s5");
        apply_reset("s5_rst");

        // Scenario 6: reset after 4 words read out.
        step();
        capture(0, 999, 0, 2, 16);
        base_pops = pops;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (pops - base_pops >= 4) break;
        end
        chk("midread_pops_in_time", 32'(n < 200), 32'd1);
        reset = 1'b1;
        mode  = 2;
        rd_if.rd_ready = 1'b0;
        q.delete();
        step();
        chk_idle("midread_rst");
        reset = 1'b0;
        mode  = 0;
        repeat (3) step();
        chk("midread_stays_idle", 32'(dut.state_q), 32'(IDLE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
- Downstream consumer of the trigger/edge-detect stage's `we` strobe in the 4-channel logic analyzer.
- While `we` is high, writes decimated 4-channel samples into an internal sample RAM. Asserts `write_finish` once DEPTH samples are stored; that is the signal the edge-detect stage waits on to drop `we`.
- Then streams the stored samples out to the host-link stage over a valid/ready interface.

Parameters:
- CH, 4, number of probe channels (sample word width).
- DEPTH, 1024, samples per capture; power of two, ≥2.
- AW, 10, address width, log2(DEPTH).
- DIV_W, 16, width of the sample-rate divisor.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write enable from the edge-detect stage; level, held until write_finish.
- data_in  in  CH  probe sample, already synchronised.
- div  in  DIV_W  sample divisor; one sample every div+1 cycles (DECIM_EN only).
- write_finish  out  1  level; high from the cycle after the last write until reset.
- busy  out  1  high in CAPTURE and READ.
- rd_valid  out  1  rd_data valid.
- rd_data  out  CH  sample word being read out.
- rd_last  out  1  qualifies the final word (address DEPTH-1).
- rd_ready  in  1  host-link stage accepts the word when rd_valid && rd_ready.

Behaviour:
- Reset (sync, clk edge with reset=1): state=IDLE, wr_addr=0, rd_addr=0, div_cnt=0. Outputs write_finish=0, busy=0, rd_valid=0, rd_last=0, rd_data=0. Reset overrides everything, including mid-capture and mid-readout; RAM contents are undefined after reset.
- States: IDLE, CAPTURE, READ, DONE.
- IDLE:
  - When we=1, write data_in to addr 0 in that same cycle (first sample = the edge sample), set wr_addr=1 and div_cnt=0, and go to CAPTURE.
- CAPTURE:
  - div_cnt increments each cycle and wraps to 0 when it equals div. A tick occurs when div_cnt==div, so div=0 ticks every cycle.
  - On a tick with we=1: write data_in to wr_addr, then wr_addr++.
  - Writing addr DEPTH-1 moves the state to READ; write_finish=1 from the next cycle.
  - If we=0 in CAPTURE: pause. No writes; div_cnt keeps running; no state change.
  - div is sampled live. A change mid-capture takes effect at the next compare; if the new div < div_cnt, the wrap happens at the counter's natural overflow.
- READ:
  - write_finish=1, busy=1. The RAM has a 1-cycle synchronous read.
  - Issue a read of rd_addr whenever (!rd_valid || rd_ready) and words remain. rd_valid rises the following cycle.
  - rd_data and rd_last are held stable while rd_valid && !rd_ready.
  - rd_last=1 exactly with the word from address DEPTH-1.
  - The handshake on the last word moves the state to DONE and clears rd_valid in the next cycle.
- DONE:
  - write_finish=1, busy=0, rd_valid=0.
  - Stays in DONE until reset. The upstream stage also re-arms only by reset.
- Simultaneous events:
  - we rising in the cycle reset deasserts: the capture begins on the next edge, not that edge.
  - rd_ready low throughout: no data lost, no address advance.
- Throughput: 1 word/cycle with rd_ready held high.

Optional Feature:
- Macro CAPTURE_CTRL_DECIM_EN.
- Defined: the `div` port and div_cnt exist, with behaviour as above.
- Undefined: the `div` port is absent, and every CAPTURE cycle with we=1 is a write tick (equivalent to div=0).

Decomposition:
- Shared package la_pkg holds:
  - the state encoding constants (IDLE=0, CAPTURE=1, READ=2, DONE=3);
  - default CH/DEPTH values;
  - the CH sample-word typedef, reused by the edge-detect and host-link stages.
- One sub-module: sample_ram, a simple dual-port RAM (write port: we/addr/din; read port: re/addr/q, 1-cycle latency). q holds its value when re=0.

Test Plan (all with DEPTH=16, AW=4):
- div=0, we asserted at cycle 10 with data_in counting 0..15 per cycle, rd_ready=1:
  - write_finish rises at cycle 26;
  - readout yields 0..15 in order;
  - rd_last is set on the 16th word only;
  - after that the state is DONE, write_finish=1 and busy=0.
- div=2 with data_in counting every cycle:
  - stored words are the edge value then every 3rd value (v, v+3, v+6, ...);
  - write_finish rises 1+15×3 cycles after we.
- Capture paused: we dropped for 5 cycles mid-capture → no addresses skipped, and write_finish is delayed by exactly 5 cycles.
- Back-pressure: rd_ready toggles with pattern 1,0,0,1 → each word is presented stable until accepted, with no duplicates or losses; rd_last is held across a stall.
- Reset mid-capture (after 7 writes) and mid-readout (after 4 reads) → next cycle all outputs are 0 and the state is IDLE; a new we starts a fresh capture at addr 0.
- CAPTURE_CTRL_DECIM_EN undefined: build without the `div` port → behaviour identical to the first scenario.
